hex_scan_ctrl: RTL and testbench
================================

# hex_scan_ctrl

Time-multiplexed scan controller for a 4-digit common-anode seven-segment display. It shares one external hex-to-segment ROM among the four digits: it presents one digit's nibble on the ROM address each scan slot and registers the returned pattern onto the segment and anode pins. Display data is double-buffered, so a new 16-bit value only takes effect at a frame boundary and never tears mid-scan. It sits between any register/counter producing hex values and the board's display pins.

## Interface
- `N`, default 18: prescaler width; one scan slot lasts 2^N clocks.
- `clk` in 1: system clock.
- `reset` in 1: asynchronous, active-high reset.
- `wr` in 1: one-cycle load strobe for `hex_in`, `dp_in` and `en_in`.
- `hex_in` in 16: digit nibbles, digit k = `hex_in[4k+3:4k]`, digit 0 rightmost.
- `dp_in` in 4: decimal points, active-high, bit k belongs to digit k.
- `en_in` in 4: digit enables, active-high; a disabled digit stays dark.
- `rom_addr` out 4: nibble of the currently selected digit, to the shared ROM.
- `rom_data` in 7: ROM pattern, active-low, bit6 = a … bit0 = g; combinational response to `rom_addr`.
- `an` out 4: anode selects, active-low.
- `sseg` out 8: `{dp_n, a,b,c,d,e,f,g}`, all active-low.
- `frame_tick` out 1: one-cycle pulse when a frame completes.

## Operation
- Prescaler `q` (N bits) is free-running. `tick` = (`q` == all ones).
- 2-bit `sel` increments on `tick` and wraps 3→0. The boundary event is `tick` while `sel` == 3.
- Shadow registers `{hex,dp,en}_s` load on `wr` and set `pending`. A second `wr` before the boundary overwrites the shadow; the last write wins.
- At the boundary with `pending` set, shadow copies to active `{hex,dp,en}_a` and `pending` clears.
- `wr` on the boundary cycle writes `hex_in`/`dp_in`/`en_in` straight to active, and also to shadow. `pending` ends at 0.
- `rom_addr` = `hex_a[4*sel+3 : 4*sel]`, combinational from `sel`.
- Registered outputs, each cycle:
  - `tick` cycle: `an` ← 1111 and `sseg` ← 8'hFF. This is the ghosting guard slot.
  - otherwise, if `en_a[sel]`: `an` ← ~(1<<`sel`) and `sseg` ← {~`dp_a[sel]`, `rom_data`}.
  - otherwise: `an` ← 1111 and `sseg` ← 8'hFF.
- `frame_tick` is registered and asserts the cycle after the boundary.
- Reset values: `q`=0, `sel`=0, every shadow and active register=0, `pending`=0, `an`=4'hF, `sseg`=8'hFF, `frame_tick`=0.
- Reset mid-frame immediately blanks the display and discards any pending data.

## Timing
- `rom_addr` to `sseg`: 1 clock, registered output.
- `sel` change to first lit output: 1 clock. The first cycle after `tick` shows the new digit. The `tick` cycle itself is blank.
- Each digit is lit for 2^N − 1 of its 2^N cycles. Frame = 4·2^N cycles.
- `wr` to visible: at most 4·2^N + 1 cycles, at least 1 (boundary write).
- After reset, the first `tick` occurs at cycle 2^N − 1 and the first boundary at cycle 4·2^N − 1.

## Structure
- Shared package `disp_pkg`:
  - `NUM_DIG` = 4
  - `SSEG_BLANK` = 8'hFF
  - `AN_OFF` = 4'hF
  - a `digit_sel_t` 2-bit typedef
- Sub-module `scan_prescaler`: N-bit counter that outputs `tick`.
- The hex-to-segment ROM is instantiated by the parent and wired to `rom_addr`/`rom_data`. It is not part of this block.

## Test plan
All scenarios use N=2: tick every 4 cycles, frame = 16 cycles. The bench models the ROM with the standard 0–F pattern table.
- **Reset:** assert `reset` for 3 cycles, then release. `an`=F, `sseg`=FF and `frame_tick`=0 during reset. After release, `an` shows digits 0,1,2,3 with every `en_a`=0, so `an` stays F.
- **Basic scan:** `wr` `hex_in`=16'h1234, `en_in`=F, `dp_in`=0 before the first boundary. After the boundary, digit 0 shows `an`=E, `sseg`=8'hCC (pattern for 4). Digit 1 shows `an`=D, `sseg`=8'h86. Each lit slot lasts 3 cycles followed by 1 blank cycle.
- **Decimal point and enable:** `dp_in`=4'b0010, `en_in`=4'b1101. Digit 1 slot shows `sseg`[7]=0. The digit 1 slot has `an`=F during its lit cycles.
- **No tearing:** `wr` 16'hAAAA, then `wr` 16'hBBBB, both mid-frame. The remainder of the frame shows the old value. The next frame shows only B (`sseg`=8'hE0) on all digits. `frame_tick` pulses once per 16 cycles.
- **Boundary collision:** `wr` 16'h0F0F exactly on the boundary cycle. The next cycle digit 0 shows F (`sseg`=8'hB8). `pending`=0, and the following frame is unchanged.
- **Reset mid-operation:** assert `reset` during the digit 2 slot. Outputs blank immediately. After release, digits show blank until a new `wr` plus a boundary.

Source files
------------

// File: rtl/disp_pkg.sv
// Shared constants and types for the seven-segment scan controller.
// Digit 0 is the rightmost digit; all pin-level polarities are active-low.
package disp_pkg;

    localparam int         NUM_DIG    = 4;
    localparam logic [7:0] SSEG_BLANK = 8'hFF;
    localparam logic [3:0] AN_OFF     = 4'hF;

    typedef logic [1:0] digit_sel_t;

    localparam digit_sel_t LAST_DIG = digit_sel_t'(NUM_DIG - 1);

    // Active-low anode pattern that lights only the selected digit.
    function automatic logic [3:0] anode_for(input digit_sel_t sel);
        return ~(4'b0001 << sel);
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Free-running N-bit prescaler; tick marks the last clock of each scan slot.
module scan_prescaler #(
    parameter int N = 18
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    logic [N-1:0] q_q;
    logic [N-1:0] q_d;

    assign q_d  = q_q + N'(1);
    assign tick = &q_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

endmodule

// File: rtl/hex_scan_ctrl.sv
// Four-digit multiplexed seven-segment scanner sharing one external hex ROM.
// Display data is double-buffered and swapped only at the frame boundary.
module hex_scan_ctrl
    import disp_pkg::*;
#(
    parameter int N = 18
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        wr,
    input  logic [15:0] hex_in,
    input  logic [3:0]  dp_in,
    input  logic [3:0]  en_in,
    output logic [3:0]  rom_addr,
    input  logic [6:0]  rom_data,
    output logic [3:0]  an,
    output logic [7:0]  sseg,
    output logic        frame_tick,
    output digit_sel_t  dbg_sel,
    output logic        dbg_pending
);

    logic        tick;
    logic        boundary;

    digit_sel_t  sel_q, sel_d;
    logic [15:0] hex_s_q, hex_s_d;
    logic [3:0]  dp_s_q, dp_s_d;
    logic [3:0]  en_s_q, en_s_d;
    logic [15:0] hex_a_q, hex_a_d;
    logic [3:0]  dp_a_q, dp_a_d;
    logic [3:0]  en_a_q, en_a_d;
    logic        pending_q, pending_d;
    logic [3:0]  an_q, an_d;
    logic [7:0]  sseg_q, sseg_d;
    logic        frame_tick_q, frame_tick_d;

    scan_prescaler #(.N(N)) u_prescaler (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    assign boundary = tick && (sel_q == LAST_DIG);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_q        <= '0;
            hex_s_q      <= '0;
            dp_s_q       <= '0;
            en_s_q       <= '0;
            hex_a_q      <= '0;
            dp_a_q       <= '0;
            en_a_q       <= '0;
            pending_q    <= 1'b0;
            an_q         <= AN_OFF;
            sseg_q       <= SSEG_BLANK;
            frame_tick_q <= 1'b0;
        end else begin
            sel_q        <= sel_d;
            hex_s_q      <= hex_s_d;
            dp_s_q       <= dp_s_d;
            en_s_q       <= en_s_d;
            hex_a_q      <= hex_a_d;
            dp_a_q       <= dp_a_d;
            en_a_q       <= en_a_d;
            pending_q    <= pending_d;
            an_q         <= an_d;
            sseg_q       <= sseg_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    // wr is a single-cycle strobe with no back-pressure: every asserted cycle
    // is accepted, and the last write before a boundary is the one displayed.
    always_comb begin
        sel_d        = tick ? sel_q + digit_sel_t'(1) : sel_q;
        hex_s_d      = hex_s_q;
        dp_s_d       = dp_s_q;
        en_s_d       = en_s_q;
        hex_a_d      = hex_a_q;
        dp_a_d       = dp_a_q;
        en_a_d       = en_a_q;
        pending_d    = pending_q;
        frame_tick_d = boundary;

        if (wr) begin
            hex_s_d   = hex_in;
            dp_s_d    = dp_in;
            en_s_d    = en_in;
            pending_d = 1'b1;
        end

        // A write landing on the boundary itself bypasses the shadow stage.
        if (boundary) begin
            if (wr) begin
                hex_a_d   = hex_in;
                dp_a_d    = dp_in;
                en_a_d    = en_in;
                pending_d = 1'b0;
            end else if (pending_q) begin
                hex_a_d   = hex_s_q;
                dp_a_d    = dp_s_q;
                en_a_d    = en_s_q;
                pending_d = 1'b0;
            end
        end
    end

    // The tick cycle is always blanked so the previous digit's pattern never
    // bleeds onto the next anode while the ROM address changes.
    always_comb begin
        an_d   = AN_OFF;
        sseg_d = SSEG_BLANK;
        if (!tick && en_a_q[sel_q]) begin
            an_d   = anode_for(sel_q);
            sseg_d = {~dp_a_q[sel_q], rom_data};
        end
    end

    assign rom_addr    = hex_a_q[{sel_q, 2'b00} +: 4];
    assign an          = an_q;
    assign sseg        = sseg_q;
    assign frame_tick  = frame_tick_q;
    assign dbg_sel     = sel_q;
    assign dbg_pending = pending_q;

endmodule

// File: tb/tb_hex_scan_ctrl.sv
// Directed bench for hex_scan_ctrl with N=2 (4-cycle slots, 16-cycle frames).
// cyc counts rising edges since reset release; outputs are sampled on the falling edge.
module tb_hex_scan_ctrl;

    localparam int N = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr = 1'b0;
    logic [15:0] hex_in = '0;
    logic [3:0]  dp_in = '0;
    logic [3:0]  en_in = '0;
    logic [3:0]  rom_addr;
    logic [6:0]  rom_data;
    logic [3:0]  an;
    logic [7:0]  sseg;
    logic        frame_tick;
    logic [1:0]  dbg_sel;
    logic        dbg_pending;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc;

    hex_scan_ctrl #(.N(N)) dut (
        .clk         (clk),
        .reset       (reset),
        .wr          (wr),
        .hex_in      (hex_in),
        .dp_in       (dp_in),
        .en_in       (en_in),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .an          (an),
        .sseg        (sseg),
        .frame_tick  (frame_tick),
        .dbg_sel     (dbg_sel),
        .dbg_pending (dbg_pending)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    always @(posedge clk or posedge reset) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1);
    end

    // Standard active-low a..g ROM for digits 0-F.
    function automatic logic [6:0] seg_of(input logic [3:0] h);
        case (h)
            4'h0: return 7'h01;  4'h1: return 7'h4F;
            4'h2: return 7'h12;  4'h3: return 7'h06;
            4'h4: return 7'h4C;  4'h5: return 7'h24;
            4'h6: return 7'h20;  4'h7: return 7'h0F;
            4'h8: return 7'h00;  4'h9: return 7'h04;
            4'hA: return 7'h08;  4'hB: return 7'h60;
            4'hC: return 7'h31;  4'hD: return 7'h42;
            4'hE: return 7'h30;  default: return 7'h38;
        endcase
    endfunction

    assign rom_data = seg_of(rom_addr);

    // ---------------- driver tasks ----------------
    task automatic step();
        @(negedge clk);
    endtask

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h (cyc %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic goto_mod(input int m);
        int guard = 0;
        while ((cyc % 16) != m && guard < 64) begin
            step();
            guard++;
        end
        if (guard >= 64) check("goto_mod_timeout", 8'd1, 8'd0);
    endtask

    task automatic goto_cyc(input int t);
        int guard = 0;
        while (cyc < t && guard < 256) begin
            step();
            guard++;
        end
        if (cyc != t) check("goto_cyc", 8'(cyc), 8'(t));
    endtask

    task automatic do_write(input logic [15:0] h, input logic [3:0] d, input logic [3:0] e);
        hex_in = h;
        dp_in  = d;
        en_in  = e;
        wr     = 1'b1;
        step();
        wr     = 1'b0;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [15:0] hex;
        logic [3:0]  dp;
        logic [3:0]  en;
        int          dig;
        logic [3:0]  exp_an;
        logic [7:0]  exp_sseg;
    } vec_t;

    vec_t vecs[12];

    initial begin
        int w;
        int f;
        int ft_count;

        vecs[0]  = '{16'h1234, 4'b0000, 4'b1111, 0, 4'hE, 8'hCC};
        vecs[1]  = '{16'h1234, 4'b0000, 4'b1111, 1, 4'hD, 8'h86};
        vecs[2]  = '{16'h1234, 4'b0000, 4'b1111, 2, 4'hB, 8'h92};
        vecs[3]  = '{16'h1234, 4'b0000, 4'b1111, 3, 4'h7, 8'hCF};
        vecs[4]  = '{16'h1234, 4'b0010, 4'b1111, 1, 4'hD, 8'h06};
        vecs[5]  = '{16'h1234, 4'b0010, 4'b1101, 1, 4'hF, 8'hFF};
        vecs[6]  = '{16'h1234, 4'b0010, 4'b1101, 0, 4'hE, 8'hCC};
        vecs[7]  = '{16'h1234, 4'b0010, 4'b1101, 3, 4'h7, 8'hCF};
        vecs[8]  = '{16'hC0DE, 4'b1000, 4'b1000, 3, 4'h7, 8'h31};
        vecs[9]  = '{16'hC0DE, 4'b1000, 4'b1000, 0, 4'hF, 8'hFF};
        vecs[10] = '{16'h89EF, 4'b0001, 4'b1111, 0, 4'hE, 8'h38};
        vecs[11] = '{16'h89EF, 4'b0001, 4'b1111, 2, 4'hB, 8'h84};

        // Reset held for 3 cycles: outputs blank.
        for (int k = 0; k < 3; k++) begin
            step();
            check("rst_an", {4'h0, an}, 8'h0F);
            check("rst_sseg", sseg, 8'hFF);
            check("rst_ft", {7'h0, frame_tick}, 8'h00);
        end
        reset = 1'b0;

        // First frame after reset: scan runs, but nothing is enabled.
        for (int k = 1; k <= 17; k++) begin
            step();
            check("idle_an", {4'h0, an}, 8'h0F);
            check("idle_sseg", sseg, 8'hFF);
            check("first_ft", {7'h0, frame_tick}, (k == 16) ? 8'h01 : 8'h00);
            if (k < 16) check("scan_sel", {6'h0, dbg_sel}, 8'((k / 4) % 4));
        end

        // Table: write mid-frame, look at the addressed digit next frame.
        for (int i = 0; i < 12; i++) begin
            goto_mod(5);
            w = cyc;
            do_write(vecs[i].hex, vecs[i].dp, vecs[i].en);
            f = w / 16 + 1;
            goto_cyc(16 * f + 4 * vecs[i].dig + 2);
            check($sformatf("vec%0d_an", i), {4'h0, an}, {4'h0, vecs[i].exp_an});
            check($sformatf("vec%0d_sseg", i), sseg, vecs[i].exp_sseg);
            goto_cyc(16 * f + 4 * vecs[i].dig + 4);
            check($sformatf("vec%0d_guard_an", i), {4'h0, an}, 8'h0F);
            check($sformatf("vec%0d_guard_sseg", i), sseg, 8'hFF);
        end

        // Digit 0 lit for 3 cycles, then the blank guard cycle.
        goto_mod(0);
        for (int k = 1; k <= 4; k++) begin
            step();
            check("slot_an", {4'h0, an}, (k < 4) ? 8'h0E : 8'h0F);
            check("slot_sseg", sseg, (k < 4) ? 8'h38 : 8'hFF);
        end

        // No tearing: two writes mid-frame, the rest of the frame stays old.
        goto_mod(5);
        w = cyc;
        do_write(16'hAAAA, 4'h0, 4'hF);
        do_write(16'hBBBB, 4'h0, 4'hF);
        f = w / 16;
        goto_cyc(16 * f + 10);
        check("tear_old_d2_an", {4'h0, an}, 8'h0B);
        check("tear_old_d2_sseg", sseg, 8'h84);
        goto_cyc(16 * f + 14);
        check("tear_old_d3_an", {4'h0, an}, 8'h07);
        check("tear_old_d3_sseg", sseg, 8'h80);
        for (int d = 0; d < 4; d++) begin
            goto_cyc(16 * (f + 1) + 4 * d + 2);
            check("tear_new_an", {4'h0, an}, {4'h0, ~(4'b0001 << d)});
            check("tear_new_sseg", sseg, 8'hE0);
        end
        ft_count = 0;
        for (int k = 0; k < 32; k++) begin
            step();
            if (frame_tick) ft_count++;
            check("ft_cycle", {7'h0, frame_tick}, ((cyc % 16) == 0) ? 8'h01 : 8'h00);
        end
        check("ft_count", 8'(ft_count), 8'd2);

        // Boundary collision: a boundary write overrides a pending shadow.
        goto_mod(5);
        do_write(16'h1111, 4'h0, 4'hF);
        check("pend_set", {7'h0, dbg_pending}, 8'h01);
        goto_mod(15);
        w = cyc;
        do_write(16'h0F0F, 4'h0, 4'hF);
        check("coll_guard_an", {4'h0, an}, 8'h0F);
        step();
        check("coll_d0_an", {4'h0, an}, 8'h0E);
        check("coll_d0_sseg", sseg, 8'hB8);
        check("coll_pending", {7'h0, dbg_pending}, 8'h00);
        f = (w + 1) / 16;
        goto_cyc(16 * f + 6);
        check("coll_d1_an", {4'h0, an}, 8'h0D);
        check("coll_d1_sseg", sseg, 8'h81);
        goto_cyc(16 * (f + 1) + 2);
        check("coll_next_d0", sseg, 8'hB8);
        goto_cyc(16 * (f + 1) + 6);
        check("coll_next_d1", sseg, 8'h81);

        // Reset during digit 2 slot with a write pending.
        goto_mod(6);
        do_write(16'h5555, 4'h0, 4'hF);
        goto_mod(10);
        check("pre_rst_an", {4'h0, an}, 8'h0B);
        reset = 1'b1;
        #1;
        check("midrst_an", {4'h0, an}, 8'h0F);
        check("midrst_sseg", sseg, 8'hFF);
        check("midrst_pending", {7'h0, dbg_pending}, 8'h00);
        step();
        step();
        reset = 1'b0;
        for (int k = 0; k < 32; k++) begin
            step();
            check("postrst_an", {4'h0, an}, 8'h0F);
            check("postrst_sseg", sseg, 8'hFF);
        end
        check("postrst_pending", {7'h0, dbg_pending}, 8'h00);
        goto_mod(5);
        w = cyc;
        do_write(16'h2222, 4'h0, 4'b0001);
        f = w / 16 + 1;
        goto_cyc(16 * f + 2);
        check("rewrite_d0_an", {4'h0, an}, 8'h0E);
        check("rewrite_d0_sseg", sseg, 8'h92);
        goto_cyc(16 * f + 6);
        check("rewrite_d1_an", {4'h0, an}, 8'h0F);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
